data_bus_bridge: RTL

- Sits directly downstream of the CPU core's data port (dAddr, dWdata, d_wr_en, store_size, load_size).
- Routes each load/store either to the on-chip data RAM (single-cycle, no stall) or to the APB peripheral region (multi-cycle, stalls the core).
- Generates byte strobes, extracts and aligns load data, and flags misaligned, slave-error and timed-out accesses.

---
 rtl/data_bus_bridge.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/data_bus_bridge.sv
// Core data-port bridge: routes loads/stores to the single-cycle data RAM or to
// the APB peripheral region, with byte-lane strobes, load alignment and error flagging.
module data_bus_bridge #(
    parameter logic [31:0] PERIPH_BASE = 32'h1000_0000,
    parameter logic [31:0] PERIPH_MASK = 32'hF000_0000,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        d_wr_en,
    input  logic        d_rd_en,
    input  logic [31:0] dAddr,
    input  logic [31:0] dWdata,
    input  logic [1:0]  store_size,
    input  logic [1:0]  load_size,
    output logic [31:0] dRdata,
    output logic        stall,
    output logic        bus_err,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_be,
    input  logic [31:0] ram_rdata,
    output logic [31:0] paddr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] pwdata,
    output logic [3:0]  pstrb,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr
);

    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, DONE = 2'd3} state_t;

    function automatic logic [3:0] lane_strobe(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] s;
        case (size)
            2'b00:   s = 4'b0001 << off;
            2'b01:   s = off[1] ? 4'b1100 : 4'b0011;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] off,
                                                 input logic [1:0] size);
        logic [31:0] sh;
        logic [31:0] r;
        sh = word >> {off, 3'b000};
        case (size)
            2'b00:   r = {24'h00_0000, sh[7:0]};
            2'b01:   r = {16'h0000, sh[15:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic [3:0]  pstrb_q, pstrb_d;
    logic        psel_q, psel_d;
    logic        penable_q, penable_d;
    logic        pwrite_q, pwrite_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;

    logic        req_s, hit_s, mis_s;
    logic [1:0]  size_s;
    logic [3:0]  strb_s;
    logic [31:0] wrep_s;
    logic        stall_s, err_s, ram_we_s;
    logic [3:0]  ram_be_s;
    logic [31:0] drdata_s;

    // Request decode: size, region, alignment, strobes and lane-replicated store data
    always_comb begin
        req_s  = d_wr_en | d_rd_en;
        size_s = d_wr_en ? store_size : load_size;
        hit_s  = (dAddr & PERIPH_MASK) == PERIPH_BASE;
        mis_s  = req_s & (((size_s == 2'b01) & dAddr[0]) | (size_s[1] & (dAddr[1:0] != 2'b00)));
        strb_s = lane_strobe(size_s, dAddr[1:0]);
        case (size_s)
            2'b00:   wrep_s = {4{dWdata[7:0]}};
            2'b01:   wrep_s = {2{dWdata[15:0]}};
            default: wrep_s = dWdata;
        endcase
    end

    // APB next-state logic plus the combinational RAM path and core-facing outputs
    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        size_d    = size_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        stall_s   = 1'b0;
        err_s     = 1'b0;
        ram_we_s  = 1'b0;
        ram_be_s  = 4'b0000;
        drdata_s  = 32'h0000_0000;
        case (state_q)
            IDLE: begin
                if (req_s && mis_s) begin
                    err_s = 1'b1;
                end else if (req_s && hit_s) begin
                    paddr_d  = dAddr;
                    pwrite_d = d_wr_en;
                    pwdata_d = wrep_s;
                    pstrb_d  = d_wr_en ? strb_s : 4'b0000;
                    size_d   = size_s;
                    psel_d   = 1'b1;
                    stall_s  = 1'b1;
                    state_d  = SETUP;
                end else if (req_s) begin
                    ram_we_s = d_wr_en;
                    ram_be_s = strb_s;
                    drdata_s = d_wr_en ? 32'h0000_0000 : load_extract(ram_rdata, dAddr[1:0], size_s);
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                stall_s   = 1'b1;
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                stall_s = 1'b1;
                if (pready) begin
                    rdata_d   = pwrite_q ? 32'h0000_0000 : load_extract(prdata, paddr_q[1:0], size_q);
                    err_d     = pslverr;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    cnt_d     = 16'd0;
                    state_d   = DONE;
                end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    rdata_d   = 32'h0000_0000;
                    err_d     = 1'b1;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    cnt_d     = 16'd0;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DONE: begin
                drdata_s = rdata_q;
                err_s    = err_q;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and APB output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            paddr_q   <= 32'h0000_0000;
            pwdata_q  <= 32'h0000_0000;
            pstrb_q   <= 4'b0000;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            size_q    <= 2'b00;
            rdata_q   <= 32'h0000_0000;
            err_q     <= 1'b0;
            cnt_q     <= 16'd0;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            size_q    <= size_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    // Reset forces the core-facing handshake quiet even while a request is still held
    assign stall     = stall_s & ~rst;
    assign bus_err   = err_s & ~rst;
    assign dRdata    = drdata_s;
    assign ram_we    = ram_we_s;
    assign ram_be    = ram_be_s;
    assign ram_addr  = {dAddr[31:2], 2'b00};
    assign ram_wdata = wrep_s;
    assign paddr     = paddr_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign pwdata    = pwdata_q;
    assign pstrb     = pstrb_q;

endmodule
